// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM states,
// parity_type encodings and error_flag bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    // parity_type encodings; 2'b00 and 2'b11 both mean no parity bit
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // error_flag bit positions
    localparam int ERR_PARITY  = 0;
    localparam int ERR_START   = 1;
    localparam int ERR_STOP    = 2;
    localparam int ERR_OVERRUN = 3;

    // 2-of-3 vote used when majority sampling is built in
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Consumer-side bundle of the UART receiver: received word, valid/ready
// handshake and status flags. master = receiver, slave = consumer.
interface uart_rx_core_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              active_flag;
    logic [3:0]        error_flag;

    modport master (
        output data_out, data_valid, active_flag, error_flag,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, active_flag, error_flag,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_tickgen.sv
// Oversample tick generator: a down-counter reloaded with i_div, giving a
// one-clock tick every i_div+1 clocks. i_restart reloads the counter so
// the tick phase is aligned to the detected start edge.
module uart_rx_tickgen #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_cnt;

    // count down, reload on terminal count or restart
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == '0)) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_tick = (r_cnt == '0) && !i_restart;
endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: synchronised serial input, oversampled bit recovery,
// optional parity, one or two stop bits, valid/ready output with overrun.
// Build option: UART_RX_MAJORITY_EN selects a 2-of-3 vote over the samples
// either side of each bit centre instead of a single centre sample.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | line idle, waiting for a synchronised falling edge
// ST_START  | checking the start bit at its centre (false start -> idle)
// ST_DATA   | shifting in DATA_W data bits, LSB first
// ST_PARITY | checking the parity bit (skipped when parity is none)
// ST_STOP1  | checking the first stop bit
// ST_STOP2  | checking the second stop bit (two-stop-bit frames only)
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OSR    = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              data_rx,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_type,
    input  logic              stop_bits,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              active_flag,
    output logic [3:0]        error_flag
);
    localparam int OS_W = $clog2(OSR);
    localparam int BC_W = $clog2(DATA_W);

    logic              r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]        r_settle;
    rx_state_t         r_state;
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_par;
    logic              r_stop2;
    logic [OS_W-1:0]   r_os;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_smp_b;
    logic              r_perr, r_serr, r_brk;
    logic              r_active, r_err_start, r_done;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid, r_out_perr, r_out_serr, r_ovr;
`ifdef UART_RX_MAJORITY_EN
    logic              r_smp_a;
`endif

    logic              w_fall, w_restart, w_tick, w_dec, w_bit;
    logic              w_par_en, w_par_exp, w_frame_perr;
    logic [DIV_W-1:0]  w_div;

    // two-flop synchroniser plus edge-detect history; r_settle masks the
    // edge detector until the chain holds real line values after reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_settle  <= 2'd0;
        end else begin
            r_rx_meta <= data_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
        end
    end

    assign w_fall    = (r_settle == 2'd3) && r_rx_prev && !r_rx_sync;
    assign w_restart = (r_state == ST_IDLE) && w_fall;
    assign w_div     = w_restart ? baud_div : r_div;

    uart_rx_tickgen #(.DIV_W(DIV_W)) u_tickgen (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_restart (w_restart),
        .i_div     (w_div),
        .o_tick    (w_tick)
    );

    // r_os starts at OSR/2 so every bit centre is the tick with r_os==OSR-1;
    // the bit is resolved one tick later in both builds so timing matches
    assign w_dec = w_tick && (r_os == '0) && (r_state != ST_IDLE);
`ifdef UART_RX_MAJORITY_EN
    assign w_bit = maj3(r_smp_a, r_smp_b, r_rx_sync);
`else
    assign w_bit = r_smp_b;
`endif
    assign w_par_en     = (r_par == PAR_ODD) || (r_par == PAR_EVEN);
    assign w_par_exp    = (^r_shift) ^ (r_par == PAR_ODD);
    // a break (all-zero frame with low stop) reports only the stop error
    assign w_frame_perr = r_perr && !(r_brk && r_serr);

    // frame FSM with sample capture and registered status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_div       <= '0;
            r_par       <= 2'b00;
            r_stop2     <= 1'b0;
            r_os        <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_smp_b     <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            r_smp_a     <= 1'b1;
`endif
            r_perr      <= 1'b0;
            r_serr      <= 1'b0;
            r_brk       <= 1'b0;
            r_active    <= 1'b0;
            r_err_start <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_err_start <= 1'b0;
            r_done      <= 1'b0;
            if (w_tick && (r_state != ST_IDLE)) begin
                r_os <= (r_os == OS_W'(OSR - 1)) ? '0 : r_os + OS_W'(1);
`ifdef UART_RX_MAJORITY_EN
                if (r_os == OS_W'(OSR - 2)) r_smp_a <= r_rx_sync;
`endif
                if (r_os == OS_W'(OSR - 1)) r_smp_b <= r_rx_sync;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_active  <= 1'b1;
                        r_div     <= baud_div;
                        r_par     <= parity_type;
                        r_stop2   <= stop_bits;
                        r_os      <= OS_W'(OSR / 2);
                        r_bit_cnt <= '0;
                        r_perr    <= 1'b0;
                        r_serr    <= 1'b0;
                        r_brk     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_dec) begin
                        if (w_bit) begin
                            r_state     <= ST_IDLE;
                            r_active    <= 1'b0;
                            r_err_start <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_dec) begin
                        r_shift   <= {w_bit, r_shift[DATA_W-1:1]};
                        r_brk     <= r_brk & ~w_bit;
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        if (r_bit_cnt == BC_W'(DATA_W - 1))
                            r_state <= w_par_en ? ST_PARITY : ST_STOP1;
                    end
                end
                ST_PARITY: begin
                    if (w_dec) begin
                        r_perr  <= (w_bit != w_par_exp);
                        r_brk   <= r_brk & ~w_bit;
                        r_state <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (w_dec) begin
                        r_serr <= ~w_bit;
                        if (r_stop2) begin
                            r_state <= ST_STOP2;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                end
                ST_STOP2: begin
                    if (w_dec) begin
                        r_serr   <= r_serr | ~w_bit;
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    // output holding register: load on completion unless the previous word
    // is still unaccepted, in which case flag overrun and keep the old word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_out_perr <= 1'b0;
            r_out_serr <= 1'b0;
            r_ovr      <= 1'b0;
        end else if (r_done && (!r_valid || data_ready)) begin
            r_data_out <= r_shift;
            r_out_perr <= w_frame_perr;
            r_out_serr <= r_serr;
            r_valid    <= 1'b1;
            r_ovr      <= 1'b0;
        end else if (r_done) begin
            r_ovr <= 1'b1;
        end else if (r_valid && data_ready) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    // error_flag bit assembly
    always_comb begin
        error_flag              = 4'b0000;
        error_flag[ERR_PARITY]  = r_out_perr;
        error_flag[ERR_START]   = r_err_start;
        error_flag[ERR_STOP]    = r_out_serr;
        error_flag[ERR_OVERRUN] = r_ovr;
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_valid;
    assign active_flag = r_active;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at OSR=16, baud_div=3 (64 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int DATA_W   = 8;
    localparam int OSR      = 16;
    localparam int DIV_W    = 16;
    localparam int BAUD_DIV = 3;
    localparam int BIT_CLKS = OSR * (BAUD_DIV + 1);
    localparam int WAIT_MAX = 1200;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              data_rx = 1'b1;
    logic [DIV_W-1:0]  baud_div = DIV_W'(BAUD_DIV);
    logic [1:0]        parity_type = 2'b00;
    logic              stop_bits = 1'b0;

    uart_rx_core_if #(.DATA_W(DATA_W)) rx_if ();

    uart_rx_core #(.DATA_W(DATA_W), .OSR(OSR), .DIV_W(DIV_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data_rx     (data_rx),
        .baud_div    (baud_div),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .data_ready  (rx_if.data_ready),
        .data_out    (rx_if.data_out),
        .data_valid  (rx_if.data_valid),
        .active_flag (rx_if.active_flag),
        .error_flag  (rx_if.error_flag)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic              got_valid;
    logic              valid_after;
    logic [DATA_W-1:0] cap_data;
    logic [3:0]        cap_err;
    logic              mid_active;
    int                serr_cycles, valid_cycles;
    logic              saw_active;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_bit(input logic v);
        data_rx = v;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input logic has_par,
                              input logic par_bit, input logic has_stop2, input logic stop2_val);
        @(negedge clock);
        hold_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) hold_bit(data[i]);
        if (has_par) hold_bit(par_bit);
        hold_bit(1'b1);
        if (has_stop2) hold_bit(stop2_val);
        hold_bit(1'b1);
    endtask

    task automatic wait_valid(input int max_cyc);
        got_valid   = 1'b0;
        valid_after = 1'b0;
        for (int i = 0; i < max_cyc && !got_valid; i++) begin
            @(negedge clock);
            if (rx_if.data_valid) begin
                got_valid = 1'b1;
                cap_data  = rx_if.data_out;
                cap_err   = rx_if.error_flag;
            end
        end
        @(negedge clock);
        valid_after = rx_if.data_valid;
    endtask

    task automatic rx_frame(input string tag, input logic [DATA_W-1:0] data, input logic has_par,
                            input logic par_bit, input logic has_stop2, input logic stop2_val,
                            input logic [DATA_W-1:0] exp_data, input logic [3:0] exp_err);
        fork
            send_frame(data, has_par, par_bit, has_stop2, stop2_val);
            wait_valid(WAIT_MAX);
        join
        check_eq({tag, "_valid"}, 32'(got_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(cap_data), 32'(exp_data));
        check_eq({tag, "_err"}, 32'(cap_err), 32'(exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rx_if.data_ready = 1'b1;
        repeat (5) @(negedge clock);
        check_eq("rst_data", 32'(rx_if.data_out), 32'h0);
        check_eq("rst_valid", 32'(rx_if.data_valid), 32'h0);
        check_eq("rst_active", 32'(rx_if.active_flag), 32'h0);
        check_eq("rst_err", 32'(rx_if.error_flag), 32'h0);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);

        // 8N1 0xA5, ready high: one-clock valid, active during frame
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
            wait_valid(WAIT_MAX);
            begin
                repeat (300) @(negedge clock);
                mid_active = rx_if.active_flag;
            end
        join
        check_eq("a5_valid", 32'(got_valid), 32'd1);
        check_eq("a5_data", 32'(cap_data), 32'hA5);
        check_eq("a5_err", 32'(cap_err), 32'h0);
        check_eq("a5_valid_1clk", 32'(valid_after), 32'd0);
        check_eq("a5_mid_active", 32'(mid_active), 32'd1);
        check_eq("a5_idle_active", 32'(rx_if.active_flag), 32'd0);

        // even parity: 0xA5 has even popcount so the correct parity bit is 0
        parity_type = 2'b10;
        rx_frame("even_bad", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 4'b0001);
        rx_frame("even_ok", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 4'b0000);

        // odd parity 0x07 (odd popcount): correct bit 0; config change mid-frame ignored
        parity_type = 2'b01;
        fork
            rx_frame("odd_latch", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 4'b0000);
            begin
                repeat (200) @(negedge clock);
                parity_type = 2'b00;
            end
        join
        parity_type = 2'b00;

        // 20-clock glitch: false start pulse, no data
        serr_cycles  = 0;
        valid_cycles = 0;
        saw_active   = 1'b0;
        for (int c = 0; c < 220; c++) begin
            data_rx = (c < 20) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (rx_if.error_flag[1]) serr_cycles++;
            if (rx_if.data_valid) valid_cycles++;
            if (rx_if.active_flag) saw_active = 1'b1;
        end
        check_eq("glitch_start_pulse", 32'(serr_cycles), 32'd1);
        check_eq("glitch_no_valid", 32'(valid_cycles), 32'd0);
        check_eq("glitch_saw_active", 32'(saw_active), 32'd1);
        check_eq("glitch_active_end", 32'(rx_if.active_flag), 32'd0);

        // two stop bits, second low, data 0x00
        stop_bits = 1'b1;
        rx_frame("stop2_low", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0100);
        stop_bits = 1'b0;

        // overrun: hold ready low across two frames
        rx_if.data_ready = 1'b0;
        rx_frame("ovr_first", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 4'b0000);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ovr_keep_data", 32'(rx_if.data_out), 32'h11);
        check_eq("ovr_flag", 32'(rx_if.error_flag[3]), 32'd1);
        check_eq("ovr_still_valid", 32'(rx_if.data_valid), 32'd1);
        rx_if.data_ready = 1'b1;
        @(negedge clock);
        check_eq("ovr_hs_valid", 32'(rx_if.data_valid), 32'd0);
        check_eq("ovr_hs_flag", 32'(rx_if.error_flag[3]), 32'd0);

        // reset in the middle of DATA with the line low, release while still low
        @(negedge clock);
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        data_rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clock);
        check_eq("mid_active_pre_rst", 32'(rx_if.active_flag), 32'd1);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("mid_rst_active", 32'(rx_if.active_flag), 32'd0);
        check_eq("mid_rst_valid", 32'(rx_if.data_valid), 32'd0);
        reset_n = 1'b1;
        serr_cycles  = 0;
        valid_cycles = 0;
        for (int c = 0; c < 2 * BIT_CLKS; c++) begin
            data_rx = (c < 10) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (rx_if.error_flag != 4'b0000) serr_cycles++;
            if (rx_if.data_valid) valid_cycles++;
        end
        check_eq("post_rst_no_err", 32'(serr_cycles), 32'd0);
        check_eq("post_rst_no_valid", 32'(valid_cycles), 32'd0);
        rx_frame("post_rst", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
